// File: rtl/tt_wb_sel_ctrl.sv
// tt_wb_sel_ctrl
//
// Wishbone slave that lets the management core pick a TinyTapeout user
// design. Firmware writes a target address and a GO bit. The block then
// drives the mux select reset pulse, the right number of increment pulses
// and finally the enable, without firmware toggling the pins by hand.
//
// Registers (word index = wbs_adr_i[3:2]):
//   0 CTRL   : bit0 GO (write 1 to start, reads 0), bit1 ENA_REQ (R/W)
//   1 TARGET : [ADDR_W-1:0] design address (R/W)
//   2 STATUS : bit0 busy, bit1 done, [16+ADDR_W-1:16] current step count (RO)
//   3        : reads 0, writes ignored
//
// Ports:
//   wb_clk_i, wb_rst_ni       clock and asynchronous active-low reset
//   wbs_stb_i/cyc_i/we_i      Wishbone classic strobe, cycle, write enable
//   wbs_adr_i, wbs_dat_i      byte address and write data
//   wbs_sel_i                 byte selects (ignored, writes are full word)
//   wbs_ack_o, wbs_dat_o      registered acknowledge and read data
//   sel_rst_n_o               mux select reset, active low
//   sel_inc_o                 mux select increment
//   ena_o                     enable for the selected design
//   busy_o                    high while a selection sequence runs

module tt_wb_sel_ctrl #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          ADDR_W   = 9,
    parameter int          PULSE_W  = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        sel_rst_n_o,
    output logic        sel_inc_o,
    output logic        ena_o,
    output logic        busy_o
);

    localparam int TMR_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PULSE_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RREC,
        S_INC_HI,
        S_INC_LO,
        S_FIN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [TMR_W-1:0]    timer;
    logic                phase_done;
    logic [ADDR_W-1:0]   tgt;
    logic [ADDR_W-1:0]   cnt;
    logic                done;
    logic                ena_req;
    logic [ADDR_W-1:0]   target_reg;

    logic                adr_match;
    logic                bus_req;
    logic                wr_en;
    logic [1:0]          reg_idx;
    logic                go_start;
    logic [31:0]         status_word;
    logic [31:0]         rd_data;
    logic                unused_inputs;

    assign adr_match = (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    // The ~ack term ends every access after one acked cycle, so a strobe
    // that is held high is acknowledged on alternating cycles.
    assign bus_req   = wbs_stb_i & wbs_cyc_i & adr_match & ~wbs_ack_o;
    assign wr_en     = bus_req & wbs_we_i;
    assign reg_idx   = wbs_adr_i[3:2];
    assign go_start  = wr_en && (reg_idx == 2'd0) && wbs_dat_i[0] && (state == S_IDLE);
    assign phase_done = (timer == TMR_LAST);

    assign unused_inputs = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

    // Live status word; busy comes straight from the state register so a
    // read during a sequence sees the step count as it advances.
    always_comb begin
        status_word              = '0;
        status_word[0]           = busy_o;
        status_word[1]           = done;
        status_word[16 +: ADDR_W] = cnt;
    end

    // Read multiplexer; GO always reads back as zero.
    always_comb begin
        rd_data = '0;
        case (reg_idx)
            2'd0: rd_data[1] = ena_req;
            2'd1: rd_data[ADDR_W-1:0] = target_reg;
            2'd2: rd_data = status_word;
            default: rd_data = '0;
        endcase
    end

    // Bus handshake: ack and read data are registered together so data is
    // valid exactly in the ack cycle, and zero otherwise.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= bus_req;
            wbs_dat_o <= bus_req ? rd_data : 32'd0;
        end
    end

    // Firmware-visible registers. TARGET may change during a sequence; the
    // running sequence works from its own latched copy in tgt.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ena_req    <= 1'b0;
            target_reg <= '0;
        end else if (wr_en) begin
            if (reg_idx == 2'd0) begin
                ena_req <= wbs_dat_i[1];
            end
            if (reg_idx == 2'd1) begin
                target_reg <= wbs_dat_i[ADDR_W-1:0];
            end
        end
    end

    // Phase timer: every pulse phase lasts PULSE_W cycles. It restarts at
    // each phase boundary and sits at zero outside the timed states.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            timer <= '0;
        end else if ((state == S_IDLE) || (state == S_FIN) || phase_done) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Sequence datapath. The step count advances when an increment pulse
    // ends, and the exit test compares for equality, so the maximum target
    // finishes without cnt ever wrapping past tgt.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tgt  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (go_start) begin
            tgt  <= target_reg;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            if ((state == S_INC_HI) && phase_done) begin
                cnt <= cnt + 1'b1;
            end
            if (state == S_FIN) begin
                done <= 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and pin outputs. Outputs decode directly from the state so
    // an asynchronous reset drops them at once without stretching a pulse.
    always_comb begin
        state_next  = state;
        sel_rst_n_o = 1'b1;
        sel_inc_o   = 1'b0;
        busy_o      = 1'b1;
        case (state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (go_start) begin
                    state_next = S_RST;
                end
            end
            S_RST: begin
                sel_rst_n_o = 1'b0;
                if (phase_done) begin
                    state_next = S_RREC;
                end
            end
            S_RREC: begin
                if (phase_done) begin
                    state_next = (tgt == '0) ? S_FIN : S_INC_HI;
                end
            end
            S_INC_HI: begin
                sel_inc_o = 1'b1;
                if (phase_done) begin
                    state_next = S_INC_LO;
                end
            end
            S_INC_LO: begin
                if (phase_done) begin
                    state_next = (cnt == tgt) ? S_FIN : S_INC_HI;
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The design is never enabled while the selection is moving.
    assign ena_o = ena_req & ~busy_o;

endmodule

// File: tb/tb_tt_wb_sel_ctrl.sv
// Self-checking bench for tt_wb_sel_ctrl. A behavioural model computes the
// expected pin waveform of each sequence from the pulse rules with plain
// arithmetic, and keeps expected register contents for readback checks.

module tb_tt_wb_sel_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          AW   = 9;
    localparam int          PW   = 2;

    logic        clk;
    logic        rst_n;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] rdat;
    logic        sel_rst_n;
    logic        sel_inc;
    logic        ena;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic          m_ena_req;
    logic [AW-1:0] m_target;
    logic [AW-1:0] m_cnt;
    logic          m_done;

    tt_wb_sel_ctrl #(
        .BASE_ADR (BASE),
        .ADDR_W   (AW),
        .PULSE_W  (PW)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_sel_i   (sel),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat),
        .sel_rst_n_o (sel_rst_n),
        .sel_inc_o   (sel_inc),
        .ena_o       (ena),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one bus access and waits (bounded) for the ack; returns at 1ns
    // after the acking edge, which is the edge where a write takes effect.
    task automatic wb_access(input logic is_wr, input logic [1:0] idx,
                             input logic [31:0] data,
                             output logic [31:0] rd, output logic acked);
        acked = 1'b0;
        rd    = '0;
        stb   = 1'b1;
        cyc   = 1'b1;
        we    = is_wr;
        adr   = BASE + {28'd0, idx, 2'b00};
        wdat  = data;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) begin
                acked = 1'b1;
                rd    = rdat;
                break;
            end
        end
        stb = 1'b0;
        cyc = 1'b0;
        we  = 1'b0;
        if (!acked) begin
            errors++;
            $display("[TB] FAIL bus_timeout idx=%0d: no ack seen, ack required", idx);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = '0;
        s[1] = m_done;
        s[16 +: AW] = m_cnt;
        return s;
    endfunction

    // Samples the pins once per cycle from the GO edge onwards and compares
    // them with the waveform implied by the pulse rules for n steps.
    task automatic watch_seq(input int n, input logic ena_req,
                             output int busy_len, output int pulses,
                             output int wave_errs);
        int   total;
        logic prev_inc;
        logic e_busy, e_rst, e_inc, e_ena;
        total     = 2*PW + 2*PW*n + 1;
        busy_len  = -1;
        pulses    = 0;
        wave_errs = 0;
        prev_inc  = 1'b0;
        for (int k = 0; k <= total + 3; k++) begin
            @(negedge clk);
            e_busy = (k < total);
            e_rst  = !(k < PW);
            e_inc  = (k >= 2*PW) && (k < 2*PW + 2*PW*n) && (((k - 2*PW) % (2*PW)) < PW);
            e_ena  = ena_req & ~e_busy;
            if ({busy, sel_rst_n, sel_inc, ena} !== {e_busy, e_rst, e_inc, e_ena}) begin
                wave_errs++;
            end
            if (sel_inc && !prev_inc) pulses++;
            prev_inc = sel_inc;
            if (!busy && busy_len < 0) busy_len = k;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        a;
        stb = 0; cyc = 0; we = 0; adr = '0; wdat = '0; sel = 4'hF;
        rst_n = 1'b0;
        m_ena_req = 0; m_target = '0; m_cnt = '0; m_done = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sel_rst_n, sel_inc, ena, busy, ack} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL reset_pins got=%b want=10000", {sel_rst_n, sel_inc, ena, busy, ack});
        end
        checks++;
        if (rdat !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_dat got=%h want=0", rdat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            wb_access(0, i[1:0], 32'd0, rd, a);
            checks++;
            if (rd !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_reg%0d got=%h want=0", i, rd);
            end
        end
    endtask

    // Full sequence: program TARGET, write GO with the chosen ENA_REQ, watch
    // every pin, then read back the registers.
    task automatic test_sequence(input int n, input logic ena_req);
        logic [31:0] rd;
        logic        a;
        int          blen, pulses, werr, total;
        total = 2*PW + 2*PW*n + 1;
        wb_access(1, 2'd1, n, rd, a);
        m_target = n[AW-1:0];
        wb_access(1, 2'd0, {30'd0, ena_req, 1'b1}, rd, a);
        m_ena_req = ena_req;
        watch_seq(n, ena_req, blen, pulses, werr);
        m_cnt  = m_target;
        m_done = 1'b1;
        checks++;
        if (blen !== total) begin
            errors++;
            $display("[TB] FAIL seq%0d_busy_len got=%0d want=%0d", n, blen, total);
        end
        checks++;
        if (pulses !== n) begin
            errors++;
            $display("[TB] FAIL seq%0d_inc_pulses got=%0d want=%0d", n, pulses, n);
        end
        checks++;
        if (werr !== 0) begin
            errors++;
            $display("[TB] FAIL seq%0d_waveform bad_cycles got=%0d want=0", n, werr);
        end
        checks++;
        if (ena !== m_ena_req) begin
            errors++;
            $display("[TB] FAIL seq%0d_ena got=%b want=%b", n, ena, m_ena_req);
        end
        wb_access(0, 2'd2, 32'd0, rd, a);
        checks++;
        if (rd !== exp_status()) begin
            errors++;
            $display("[TB] FAIL seq%0d_status got=%h want=%h", n, rd, exp_status());
        end
        wb_access(0, 2'd0, 32'd0, rd, a);
        checks++;
        if (rd !== {30'd0, m_ena_req, 1'b0}) begin
            errors++;
            $display("[TB] FAIL seq%0d_ctrl got=%h want=%h", n, rd, {30'd0, m_ena_req, 1'b0});
        end
    endtask

    task automatic test_random();
        int   n;
        logic e;
        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(0, 12);
            e = 1'($urandom_range(0, 1));
            test_sequence(n, e);
        end
    endtask

    // GO and TARGET written mid-sequence: both acked, neither disturbs the
    // running sequence, and TARGET reads the new value afterwards.
    task automatic test_go_while_busy();
        logic [31:0] rd, rd_st;
        logic        a_go, a_tg, a_st;
        int          blen, pulses, werr;
        wb_access(1, 2'd1, 32'd5, rd, a_go);
        m_target = 5;
        wb_access(1, 2'd0, 32'h1, rd, a_go);
        m_ena_req = 0;
        fork
            watch_seq(5, 1'b0, blen, pulses, werr);
            begin
                repeat (5) @(posedge clk);
                #1;
                wb_access(1, 2'd0, 32'h1, rd, a_go);
                wb_access(1, 2'd1, 32'h1, rd, a_tg);
                m_target = 1;
                wb_access(0, 2'd2, 32'd0, rd_st, a_st);
            end
        join
        m_cnt  = 5;
        m_done = 1;
        checks++;
        if (a_go !== 1'b1 || a_tg !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_write_ack got=%b%b want=11", a_go, a_tg);
        end
        checks++;
        if (rd_st[1:0] !== 2'b01) begin
            errors++;
            $display("[TB] FAIL busy_status_live got=%b want=01", rd_st[1:0]);
        end
        checks++;
        if (pulses !== 5 || werr !== 0 || blen !== 2*PW + 2*PW*5 + 1) begin
            errors++;
            $display("[TB] FAIL busy_seq pulses=%0d errs=%0d len=%0d want 5/0/%0d",
                     pulses, werr, blen, 2*PW + 2*PW*5 + 1);
        end
        wb_access(0, 2'd1, 32'd0, rd, a_tg);
        checks++;
        if (rd !== 32'd1) begin
            errors++;
            $display("[TB] FAIL busy_target_readback got=%h want=1", rd);
        end
        wb_access(0, 2'd2, 32'd0, rd, a_tg);
        checks++;
        if (rd !== exp_status()) begin
            errors++;
            $display("[TB] FAIL busy_status_end got=%h want=%h", rd, exp_status());
        end
    endtask

    // Reset asserted during the second increment pulse must drop every pin
    // at once; a new sequence afterwards must run cleanly.
    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        a;
        wb_access(1, 2'd1, 32'd4, rd, a);
        wb_access(1, 2'd0, 32'h3, rd, a);
        // Cycle 2*PW + 2*PW is the first cycle of the second increment pulse.
        repeat (4*PW + 1) @(negedge clk);
        checks++;
        if (sel_inc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_inc_before_reset got=%b want=1", sel_inc);
        end
        #2;
        rst_n = 1'b0;
        m_ena_req = 0; m_target = '0; m_cnt = '0; m_done = 0;
        #1;
        checks++;
        if ({sel_rst_n, sel_inc, ena, busy, ack} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL mid_reset_pins got=%b want=10000", {sel_rst_n, sel_inc, ena, busy, ack});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wb_access(0, 2'd2, 32'd0, rd, a);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("[TB] FAIL mid_status_after_reset got=%h want=0", rd);
        end
        test_sequence(2, 1'b1);
    endtask

    task automatic test_bus();
        logic [31:0] rd;
        logic        a;
        int          acks;
        logic [5:0]  pat, exp_pat;
        // Non-matching addresses: no ack within 4 cycles.
        acks = 0;
        stb = 1; cyc = 1; we = 0; adr = BASE + 32'h10;
        repeat (4) begin @(posedge clk); #1; if (ack) acks++; end
        adr = 32'h4000_0000;
        repeat (4) begin @(posedge clk); #1; if (ack) acks++; end
        stb = 0; cyc = 0;
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("[TB] FAIL nomatch_ack got=%0d acks want=0", acks);
        end
        // Held strobe on a matching address: ack every other cycle.
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = 0; adr = BASE + 32'h8;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pat[i]     = ack;
            exp_pat[i] = (i % 2 == 0);
        end
        stb = 0; cyc = 0;
        checks++;
        if (pat !== exp_pat) begin
            errors++;
            $display("[TB] FAIL held_strobe_ack got=%b want=%b", pat, exp_pat);
        end
        @(posedge clk); #1;
        // Index 3 ignores writes and reads zero.
        wb_access(1, 2'd3, 32'hFFFF_FFFF, rd, a);
        wb_access(0, 2'd3, 32'd0, rd, a);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("[TB] FAIL idx3_read got=%h want=0", rd);
        end
    endtask

    initial begin
        test_reset();
        test_sequence(3, 1'b1);
        test_sequence(0, 1'b0);
        test_go_while_busy();
        test_reset_mid();
        test_random();
        test_sequence((1 << AW) - 1, 1'b1);
        test_bus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_wb_sel_ctrl.md
# tt_wb_sel_ctrl

Wishbone-slave sequencer that selects and enables one TinyTapeout user design from the Caravel management core, replacing manual toggling of the mux control pins. It sits in the user project wrapper between the Wishbone slave port, currently tied off, and the `tt_top` selection inputs. Firmware writes a target design address and a GO bit. The block then issues the mux reset pulse, the exact number of increment pulses and the final enable.

## Interface
- `BASE_ADR`, default 32'h3000_0000: register window base; decode is `wbs_adr_i[31:4] == BASE_ADR[31:4]`.
- `ADDR_W`, default 9: width of the design address and step counter.
- `PULSE_W`, default 2: length in cycles of every pulse phase; must be ≥1.
- `wb_clk_i`  in  1: the single clock; all logic is on the rising edge.
- `wb_rst_ni`  in  1: asynchronous, active-low reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each: Wishbone classic strobe, cycle and write-enable.
- `wbs_adr_i`  in  32: byte address; register index is `[3:2]`.
- `wbs_dat_i`  in  32: write data.
- `wbs_sel_i`  in  4: ignored; all writes are full-word.
- `wbs_ack_o`  out  1: registered acknowledge.
- `wbs_dat_o`  out  32: registered read data.
- `sel_rst_n_o`  out  1: mux select reset, active low.
- `sel_inc_o`  out  1: mux select increment.
- `ena_o`  out  1: enable for the selected design.
- `busy_o`  out  1: high while a sequence runs.

## Operation
- Registers, by word index:
  - 0 CTRL: bit0 GO (write-1-to-start, reads 0); bit1 ENA_REQ (R/W).
  - 1 TARGET: `[ADDR_W-1:0]`, R/W.
  - 2 STATUS, read-only: bit0 busy; bit1 done; `[16+ADDR_W-1:16]` current step count.
  - 3: reads 0; writes are ignored.
- Bus handshake:
  - `ack <= stb & cyc & match & ~ack`. A held strobe is therefore acked every other cycle.
  - An address that does not match `BASE_ADR` gets no ack.
  - A write takes effect on the same edge that raises ack.
- Writing GO=1 while idle:
  - Latches TARGET into `tgt`.
  - Clears `cnt` and done.
  - Moves the FSM to RST.
- Writing GO=1 while busy is acked and ignored. Writing TARGET while busy updates the register but does not affect the running sequence.
- FSM states and actions. A phase timer counts PULSE_W cycles per state.
  - IDLE: `sel_rst_n_o`=1, `sel_inc_o`=0.
  - RST: `sel_rst_n_o`=0 for PULSE_W cycles, then → RREC.
  - RREC: `sel_rst_n_o`=1 for PULSE_W cycles. If `tgt`==0, → FIN; otherwise → INC_HI.
  - INC_HI: `sel_inc_o`=1 for PULSE_W cycles. `cnt` increments on exit, then → INC_LO.
  - INC_LO: `sel_inc_o`=0 for PULSE_W cycles. If `cnt`==`tgt`, → FIN; otherwise → INC_HI.
  - FIN: lasts 1 cycle; sets done, then → IDLE.
- `busy_o` is 1 in every state except IDLE.
- `ena_o` = ENA_REQ & ~busy. It is forced to 0 for the whole sequence, so a design is never enabled while the selection is moving.
- `cnt` and `tgt` are ADDR_W bits wide. A TARGET of 2^ADDR_W−1 must complete without wrap. `cnt` never exceeds `tgt`.

## Timing
- Reset values:
  - `wbs_ack_o`=0, `wbs_dat_o`=0.
  - `sel_rst_n_o`=1, `sel_inc_o`=0, `ena_o`=0, `busy_o`=0.
  - State IDLE; CTRL, TARGET, `cnt` and done all 0.
- Asserting reset mid-sequence aborts immediately to these values, asynchronously. No partial pulse is extended.
- Let the GO write edge be E. `busy_o` rises at E, and `sel_rst_n_o` falls at E.
- `busy_o` falls exactly `2·PULSE_W + 2·PULSE_W·N + 1` cycles after E, where N is the latched target. Done rises on the same edge.
- `ena_o` follows ENA_REQ with 0 cycles of latency relative to the register and busy flops.
- Read data is registered and valid in the cycle where ack is high.
- A STATUS read during a sequence returns live values: busy=1 and the current `cnt`.
- An increment pulse is always followed by a low phase of at least PULSE_W cycles before FIN.

## Test plan
- Reset, then read all 4 registers: CTRL=0, TARGET=0, STATUS=0, index3=0. Outputs read `sel_rst_n_o`=1, `sel_inc_o`=0, `ena_o`=0, `busy_o`=0.
- PULSE_W=2, TARGET=3, CTRL=0x3:
  - `sel_rst_n_o` low for 2 cycles, then high for 2.
  - Exactly 3 `sel_inc_o` pulses, each 2 cycles high and 2 cycles low.
  - `busy_o` lasts 17 cycles, then `ena_o`=1.
  - STATUS reads 0x0003_0002.
- TARGET=0, GO: reset pulse only, no `sel_inc_o` pulses, busy lasts 5 cycles, done=1.
- GO with TARGET=5. At cycle 6, write GO and TARGET=1: the ack is returned, the sequence still produces 5 increments, and TARGET then reads 1.
- Assert `wb_rst_ni` during the 2nd INC_HI: all outputs return to their reset values asynchronously. A new GO with TARGET=2 then runs cleanly.
- An access with a non-matching BASE_ADR gets no ack within 4 cycles. A held strobe on a matching address gets ack on alternating cycles.
